io_arbiter: RTL and testbench

Round-robin arbiter that shares the single 8-bit output-port write path into the `e_s` port register bank (`s1`..`s4`) among four requesters (CPU I/O unit plus up to three peripheral masters). It sequences each grant as a burst of one-per-cycle writes, bounded by `MAX_HOLD` when others are waiting, and acknowledges every committed write to its owner. Sits between the requesters and the port bank write enable, id and data inputs.

---
 rtl/io_arbiter.sv | 153 +++++++++++++++
 tb/tb_io_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// io_arbiter: round-robin owner of the single 8-bit write path
// into the e_s port bank (s1..s4), shared by four requesters.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low
//   req[3:0]  per-requester request, held while writing
//   port_id   2-bit target per requester (i -> [2i+1:2i])
//   wdata_in  8-bit data per requester (i -> [8i+7:8i])
//   gnt       one-hot grant, zero when idle
//   ack       one-cycle pulse on owner bit, aligned with we
//   we/wid/wdata  port bank write enable, select, data
//   busy      OR of gnt
module io_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [7:0]  port_id,
  input  logic [31:0] wdata_in,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        we,
  output logic [1:0]  wid,
  output logic [7:0]  wdata,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  own_q, own_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  ack_q, ack_d;
  logic        we_q, we_d;
  logic [1:0]  wid_q, wid_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;

  logic [1:0]  pick;
  logic        pick_vld;
  logic [3:0]  own_oh;
  logic [3:0]  others;
  logic        hold_done;
  logic        rel;
  logic [1:0]  own_wid;
  logic [7:0]  own_wdata;

  // Rotating search from ptr; walk offsets high to low
  // so the smallest offset with a request wins.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        pick     = ptr_q + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    own_oh    = 4'b0001 << own_q;
    others    = req & ~own_oh;
    hold_done = (cnt_q == HOLD);
    rel       = ~req[own_q]
              | (hold_done & (|others));
    own_wid   = port_id[{own_q, 1'b0} +: 2];
    own_wdata = wdata_in[{own_q, 3'b000} +: 8];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ack_d   = 4'b0000;
    we_d    = 1'b0;
    wid_d   = wid_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (pick_vld) begin
          own_d   = pick;
          gnt_d   = 4'b0001 << pick;
          cnt_d   = 4'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (rel) begin
          gnt_d   = 4'b0000;
          ptr_d   = own_q + 2'd1;
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          ack_d   = own_oh;
          wid_d   = own_wid;
          wdata_d = own_wdata;
          // A lone owner parks at HOLD and keeps writing.
          cnt_d   = hold_done ? cnt_q
                              : cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      own_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
      ack_q   <= 4'b0000;
      we_q    <= 1'b0;
      wid_q   <= 2'd0;
      wdata_q <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      wid_q   <= wid_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign we    = we_q;
  assign wid   = wid_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed bench for io_arbiter with a
// per-cycle reference model and literal scenario checks.
module tb_io_arbiter;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  port_id;
  logic [31:0] wdata_in;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        we;
  logic [1:0]  wid;
  logic [7:0]  wdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  io_arbiter #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .req      (req),
    .port_id  (port_id),
    .wdata_in (wdata_in),
    .gnt      (gnt),
    .ack      (ack),
    .we       (we),
    .wid      (wid),
    .wdata    (wdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: owner index (-1 = nobody),
  // next-search start and writes done in this grant.
  int          m_own = -1;
  int          m_ptr = 0;
  int          m_burst = 0;
  int          m_i;
  logic [3:0]  s_req;
  logic [7:0]  s_pid;
  logic [31:0] s_wd;
  logic [3:0]  e_gnt = 0;
  logic [3:0]  e_ack = 0;
  logic        e_we = 0;
  logic [1:0]  e_wid = 0;
  logic [7:0]  e_wdata = 0;
  int          wr_cnt[4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    s_req = req;
    s_pid = port_id;
    s_wd  = wdata_in;
    if (!rst_n) begin
      m_own = -1; m_ptr = 0; m_burst = 0;
      e_gnt = 0; e_ack = 0; e_we = 0;
      e_wid = 0; e_wdata = 0;
    end else if (m_own < 0) begin
      e_gnt = 0; e_ack = 0; e_we = 0;
      for (int k = 0; k < 4; k++) begin
        m_i = (m_ptr + k) % 4;
        if (m_own < 0 && s_req[m_i]) begin
          m_own   = m_i;
          m_burst = 0;
          e_gnt   = 4'(1 << m_i);
        end
      end
    end else if (!s_req[m_own] ||
                 (m_burst >= MH &&
                  (s_req & ~4'(1 << m_own)) != 0)) begin
      m_ptr = (m_own + 1) % 4;
      m_own = -1;
      e_gnt = 0; e_ack = 0; e_we = 0;
    end else begin
      e_we    = 1;
      e_ack   = 4'(1 << m_own);
      e_wid   = s_pid[2*m_own +: 2];
      e_wdata = s_wd[8*m_own +: 8];
      m_burst++;
    end
    #1;
    chk("m_gnt", gnt, e_gnt);
    chk("m_ack", ack, e_ack);
    chk("m_we", we, e_we);
    chk("m_wid", wid, e_wid);
    chk("m_wdata", wdata, e_wdata);
    chk("m_busy", busy, e_gnt != 0);
    if (we)
      for (int i = 0; i < 4; i++)
        if (ack[i]) wr_cnt[i]++;
  end

  int n;
  int base;
  int prev_gnt;
  int idle_run;
  int ng;
  int own_seq[8];
  int wr_seq[8];
  int gap_seq[8];
  int exp_own[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 0; req = 0; port_id = 0; wdata_in = 0;
    nedge(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_we", we, 0);
    chk("rst_all", {gnt, ack, we, wid, wdata, busy}, 0);

    // data routing, requester 1
    rst_n = 1;
    port_id = 8'b0000_1100;
    wdata_in = 32'h0000_A500;
    req = 4'b0010;
    nedge(1);
    chk("route_gnt", gnt, 4'b0010);
    chk("route_we0", we, 0);
    nedge(1);
    chk("route_we", we, 1);
    chk("route_wid", wid, 3);
    chk("route_wdata", wdata, 8'hA5);
    chk("route_ack", ack, 4'b0010);
    req = 0;
    nedge(1);
    chk("route_rel", gnt, 0);
    nedge(1);

    // lone requester 2, ten writes
    port_id = 8'b0010_0000;
    wdata_in = 32'h0010_0000;
    req = 4'b0100;
    nedge(1);
    chk("lone_gnt", gnt, 4'b0100);
    for (int k = 0; k < 10; k++) begin
      nedge(1);
      chk("lone_we", we, 1);
      chk("lone_wdata", wdata, 8'h10 + 8'(k));
      chk("lone_ack", ack, 4'b0100);
      chk("lone_gnt_hold", gnt, 4'b0100);
      wdata_in[23:16] = 8'h11 + 8'(k);
    end
    req = 0;
    nedge(1);
    chk("lone_rel", gnt, 0);
    nedge(1);

    // pointer wrap: ptr is 3, 0 beats 2
    req = 4'b0101;
    nedge(1);
    chk("wrap_first", gnt, 4'b0001);
    n = 0;
    do begin
      nedge(1);
      n++;
    end while (!(gnt != 0 && gnt != 4'b0001) && n < 20);
    chk("wrap_second", gnt, 4'b0100);
    req = 0;
    nedge(2);

    // early drop by owner 0 with 3 waiting
    req = 4'b0001;
    nedge(1);
    chk("drop_gnt0", gnt, 4'b0001);
    base = wr_cnt[0];
    req = 4'b1001;
    nedge(2);
    req = 4'b1000;
    nedge(1);
    chk("drop_idle", gnt, 0);
    nedge(1);
    chk("drop_gnt3", gnt, 4'b1000);
    chk("drop_writes", wr_cnt[0] - base, 2);
    req = 0;
    nedge(2);

    // full contention from reset release
    rst_n = 0;
    req = 4'b1111;
    nedge(1);
    rst_n = 1;
    prev_gnt = 0; idle_run = 0; ng = 0;
    for (int k = 0; k < 32; k++) begin
      nedge(1);
      if (gnt != 0 && prev_gnt == 0 && ng < 8) begin
        own_seq[ng] = oh2i(gnt);
        gap_seq[ng] = idle_run;
        wr_seq[ng] = 0;
        ng++;
      end
      if (gnt == 0) idle_run++;
      else idle_run = 0;
      if (we && ng > 0) wr_seq[ng-1]++;
      prev_gnt = int'(gnt);
    end
    chk("full_ngrants", ng >= 5, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < ng) begin
        chk("full_owner", own_seq[i], exp_own[i]);
        if (i < 4) chk("full_writes", wr_seq[i], 4);
        if (i > 0) chk("full_gap", gap_seq[i], 1);
      end
    end

    // reset mid-burst
    n = 0;
    while (!we && n < 10) begin
      nedge(1);
      n++;
    end
    chk("mid_we_seen", we, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_async", {gnt, ack, we, wid, wdata, busy}, 0);
    req = 4'b0001;
    port_id = 8'b0000_0010;
    nedge(1);
    rst_n = 1;
    nedge(1);
    chk("mid_gnt", gnt, 4'b0001);
    chk("mid_we0", we, 0);
    nedge(1);
    chk("mid_we", we, 1);
    chk("mid_wid", wid, 2);
    chk("mid_ack", ack, 4'b0001);
    req = 0;
    nedge(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
